ps2_keyboard: RTL and testbench



---
 rtl/ps2_keyboard.sv | 99 +++++++++
 tb/tb_ps2_keyboard.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/ps2_keyboard.sv
// ps2_keyboard: PS/2 device-to-host receiver with glitch filter, frame checks and a scancode FIFO.
module ps2_keyboard #(
  parameter int FIFO_AW = 3,
  parameter int TIMEOUT = 25000,
  parameter int FILTER  = 8
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       ps2_clk,
  input  logic       ps2_dat,
  input  logic       rd,
  input  logic       clr,
  output logic [7:0] data,
  output logic       ready,
  output logic       overflow,
  output logic       perr
);
  localparam int FW = $clog2(FILTER + 1);
  localparam int WW = $clog2(TIMEOUT + 1);
  typedef enum logic [1:0] {IDLE, RECV, CHECK} state_t;
  state_t state, state_nx;
  logic ck_s1, ck_s2, dt_s1, dt_s2, ck_f, fall;
  logic [FW-1:0] fcnt;
  logic [WW-1:0] wd;
  logic [3:0] bcnt;
  logic [7:0] sreg;
  logic par, stop, ok, push, pop, wr, full, empty;
  logic [FIFO_AW:0] wp, rp;
  logic [7:0] mem [2**FIFO_AW];
  // Filtered clock flips only after FILTER consecutive samples disagree with it
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      {ck_s1, ck_s2, dt_s1, dt_s2, ck_f} <= '1;
      fcnt <= '0;
      fall <= 1'b0;
    end else begin
      {ck_s1, ck_s2, dt_s1, dt_s2} <= {ps2_clk, ck_s1, ps2_dat, dt_s1};
      fall <= ck_f & ~ck_s2 & (fcnt == FW'(FILTER - 1));
      if (ck_s2 == ck_f) fcnt <= '0;
      else if (fcnt == FW'(FILTER - 1)) begin
        ck_f <= ck_s2;
        fcnt <= '0;
      end else fcnt <= fcnt + 1'b1;
    end
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:  state_nx = (fall && !dt_s2) ? RECV : IDLE;
      RECV:  state_nx = (fall && bcnt == 4'd10) ? CHECK : (!fall && wd == WW'(TIMEOUT)) ? IDLE : RECV;
      CHECK: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end
  // Bit counter: start bit is 0, data 1..8, parity 9, stop 10
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      wd <= '0;
      bcnt <= '0;
      sreg <= '0;
      par <= 1'b0;
      stop <= 1'b0;
    end else if (state == IDLE) begin
      wd <= '0;
      if (fall && !dt_s2) bcnt <= 4'd1;
    end else if (state == RECV) begin
      if (fall) begin
        wd <= '0;
        bcnt <= bcnt + 1'b1;
        if (bcnt <= 4'd8) sreg <= {dt_s2, sreg[7:1]};
        else if (bcnt == 4'd9) par <= dt_s2;
        else stop <= dt_s2;
      end else wd <= wd + 1'b1;
    end
  assign ok    = (^{sreg, par}) & stop;
  assign push  = (state == CHECK) & ok;
  assign empty = wp == rp;
  assign full  = (wp[FIFO_AW] != rp[FIFO_AW]) && (wp[FIFO_AW-1:0] == rp[FIFO_AW-1:0]);
  assign pop   = rd & ~empty;
  assign wr    = push & (~full | pop);
  assign ready = ~empty;
  assign data  = empty ? 8'h00 : mem[rp[FIFO_AW-1:0]];
  always_ff @(posedge clock)
    if (wr) mem[wp[FIFO_AW-1:0]] <= sreg;
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      wp <= '0;
      rp <= '0;
      overflow <= 1'b0;
      perr <= 1'b0;
    end else begin
      if (wr) wp <= wp + 1'b1;
      if (pop) rp <= rp + 1'b1;
      overflow <= (push & full & ~pop) | (overflow & ~clr);
      perr <= ((state == CHECK) & ~ok) | (perr & ~clr);
    end
endmodule

// File: tb/tb_ps2_keyboard.sv
// tb_ps2_keyboard: directed frames with hand-computed expectations for ps2_keyboard.
module tb_ps2_keyboard;
  localparam int H = 20;
  localparam int TO = 200;
  logic clock, reset_n, ps2_clk, ps2_dat, rd, clr;
  logic [7:0] data;
  logic ready, overflow, perr;
  int vectors = 0, miscompares = 0;
  ps2_keyboard #(.FIFO_AW(3), .TIMEOUT(TO), .FILTER(8)) dut (
    .clock(clock), .reset_n(reset_n), .ps2_clk(ps2_clk), .ps2_dat(ps2_dat),
    .rd(rd), .clr(clr), .data(data), .ready(ready), .overflow(overflow), .perr(perr)
  );
  initial clock = 1'b0;
  always #5 clock = ~clock;
  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic wait_n(input int n);
    repeat (n) @(negedge clock);
  endtask
  task automatic pop();
    @(negedge clock) rd = 1'b1;
    @(negedge clock) rd = 1'b0;
  endtask
  task automatic clear();
    @(negedge clock) clr = 1'b1;
    @(negedge clock) clr = 1'b0;
  endtask
  // mode 1: check exact byte latency at the stop bit; mode 2: pulse rd on the push edge
  task automatic frame(input logic [7:0] b, input logic pbad, input logic stp,
                       input int nbits, input int mode, input int gbit);
    logic [10:0] bits;
    bits = {stp, ~^b ^ pbad, b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      ps2_dat = bits[i];
      if (i == gbit) begin
        wait_n(5);
        ps2_clk = 1'b0;
        wait_n(3);
        ps2_clk = 1'b1;
        wait_n(H - 8);
      end else wait_n(H);
      ps2_clk = 1'b0;
      if (i == nbits - 1 && mode != 0) begin
        wait_n(11);
        if (mode == 1) chk("lat_early", {7'd0, ready}, 8'h00);
        if (mode == 2) rd = 1'b1;
        wait_n(1);
        rd = 1'b0;
        if (mode == 1) begin
          chk("lat_ready", {7'd0, ready}, 8'h01);
          chk("lat_data", data, b);
        end
        wait_n(H - 12);
      end else wait_n(H);
      ps2_clk = 1'b1;
    end
    ps2_dat = 1'b1;
    wait_n(H);
  endtask
  initial begin
    logic [7:0] e;
    reset_n = 1'b0; ps2_clk = 1'b1; ps2_dat = 1'b1; rd = 1'b0; clr = 1'b0;
    wait_n(3);
    chk("rst_data", data, 8'h00);
    chk("rst_ready", {7'd0, ready}, 8'h00);
    chk("rst_ovf", {7'd0, overflow}, 8'h00);
    chk("rst_perr", {7'd0, perr}, 8'h00);
    reset_n = 1'b1;
    wait_n(5);
    frame(8'h1C, 1'b0, 1'b1, 11, 1, -1);
    chk("f1c_data", data, 8'h1C);
    chk("f1c_perr", {7'd0, perr}, 8'h00);
    pop();
    chk("pop_ready", {7'd0, ready}, 8'h00);
    chk("pop_data", data, 8'h00);
    frame(8'h1C, 1'b1, 1'b1, 11, 0, -1);
    chk("par_ready", {7'd0, ready}, 8'h00);
    chk("par_perr", {7'd0, perr}, 8'h01);
    clear();
    chk("clr_perr", {7'd0, perr}, 8'h00);
    frame(8'h1C, 1'b0, 1'b0, 11, 0, -1);
    chk("stop_perr", {7'd0, perr}, 8'h01);
    chk("stop_ready", {7'd0, ready}, 8'h00);
    clear();
    for (int i = 1; i <= 9; i++) frame(8'(i), 1'b0, 1'b1, 11, 0, -1);
    chk("ovf_set", {7'd0, overflow}, 8'h01);
    for (int i = 1; i <= 8; i++) begin
      chk("ovf_order", data, 8'(i));
      pop();
    end
    chk("ovf_empty", {7'd0, ready}, 8'h00);
    chk("ovf_sticky", {7'd0, overflow}, 8'h01);
    clear();
    chk("ovf_clr", {7'd0, overflow}, 8'h00);
    for (int i = 0; i < 8; i++) frame(8'h11 + 8'(i), 1'b0, 1'b1, 11, 0, -1);
    frame(8'h77, 1'b0, 1'b1, 11, 2, -1);
    chk("fullrd_ovf", {7'd0, overflow}, 8'h00);
    for (int i = 0; i < 8; i++) begin
      e = (i < 7) ? 8'h12 + 8'(i) : 8'h77;
      chk("fullrd_data", data, e);
      pop();
    end
    chk("fullrd_empty", {7'd0, ready}, 8'h00);
    ps2_clk = 1'b0;
    wait_n(3);
    ps2_clk = 1'b1;
    wait_n(H);
    frame(8'hF0, 1'b0, 1'b1, 11, 0, 3);
    chk("glitch_data", data, 8'hF0);
    pop();
    chk("glitch_one", {7'd0, ready}, 8'h00);
    chk("glitch_perr", {7'd0, perr}, 8'h00);
    frame(8'h00, 1'b0, 1'b1, 5, 0, -1);
    wait_n(TO + 10);
    frame(8'hF0, 1'b0, 1'b1, 11, 0, -1);
    chk("to_data", data, 8'hF0);
    pop();
    chk("to_one", {7'd0, ready}, 8'h00);
    chk("to_perr", {7'd0, perr}, 8'h00);
    frame(8'hA1, 1'b0, 1'b1, 11, 0, -1);
    frame(8'hA2, 1'b0, 1'b1, 11, 0, -1);
    frame(8'hA3, 1'b1, 1'b1, 11, 0, -1);
    chk("pre_rst_data", data, 8'hA1);
    chk("pre_rst_perr", {7'd0, perr}, 8'h01);
    frame(8'h33, 1'b0, 1'b1, 5, 0, -1);
    @(negedge clock) reset_n = 1'b0;
    #1;
    chk("mid_rst_data", data, 8'h00);
    chk("mid_rst_ready", {7'd0, ready}, 8'h00);
    chk("mid_rst_perr", {7'd0, perr}, 8'h00);
    chk("mid_rst_ovf", {7'd0, overflow}, 8'h00);
    wait_n(3);
    reset_n = 1'b1;
    wait_n(5);
    frame(8'h5A, 1'b0, 1'b1, 11, 0, -1);
    chk("post_rst_data", data, 8'h5A);
    pop();
    chk("post_rst_one", {7'd0, ready}, 8'h00);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
